// File: rtl/cpu_fetch.sv
// Instruction fetch unit: reads 1- or 2-byte instructions from RAM and presents them to the control unit.
// Latency: byte-1 read at T, instruction valid at T+2 (1-byte) or T+4 (2-byte); RAM data returns one cycle after the read strobe.
// Backpressure: instruction held on oinst_vld until iinst_rdy; no new read is issued while an instruction waits.
module cpu_fetch #(
    parameter int                     pDATA_WIDTH = 8,
    parameter logic [pDATA_WIDTH-1:0] pEND_CODE   = 8'hCF
) (
    input  logic                   iclk,
    input  logic                   irst,
    input  logic                   ien,
    output logic                   oram_rd,
    output logic [pDATA_WIDTH-1:0] oram_addr,
    input  logic [pDATA_WIDTH-1:0] iram_data,
    output logic                   oinst_vld,
    input  logic                   iinst_rdy,
    output logic [pDATA_WIDTH-1:0] oinst_data,
    output logic [pDATA_WIDTH-1:0] oimm_data,
    output logic                   oinst_len2,
    input  logic                   ijmp,
    input  logic [pDATA_WIDTH-1:0] ijmp_addr,
    output logic [pDATA_WIDTH-1:0] opc,
    output logic                   ohalt
);

    // Opcode classes (upper nibble of byte 1) that carry a second byte.
    localparam logic [3:0] OP_DATA = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;

    localparam logic [pDATA_WIDTH-1:0] PC_ONE  = 1;
    localparam logic [pDATA_WIDTH-1:0] ZERO_DW = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F1   = 3'd1,
        ST_F1W  = 3'd2,
        ST_F2   = 3'd3,
        ST_F2W  = 3'd4,
        ST_OUT  = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [pDATA_WIDTH-1:0] pc_q,    pc_d;
    logic [pDATA_WIDTH-1:0] inst_q,  inst_d;
    logic [pDATA_WIDTH-1:0] imm_q,   imm_d;
    logic                   len2_q,  len2_d;

    logic [3:0] byte1_op;
    logic       byte1_two;
    logic       xfer;
    logic       end_xfer;
    logic       redirect;

    // Decode the byte arriving from RAM; only meaningful while capturing byte 1.
    assign byte1_op  = iram_data[pDATA_WIDTH-1 -: 4];
    assign byte1_two = (byte1_op == OP_DATA) || (byte1_op == OP_JMP) || (byte1_op == OP_J);

    // A presented instruction moves when the control unit is ready; END transfers block redirects.
    assign xfer     = (state_q == ST_OUT) && iinst_rdy;
    assign end_xfer = xfer && (inst_q == pEND_CODE);
    assign redirect = ijmp && (state_q != ST_HALT) && !end_xfer;

    // Next-state, PC and instruction-register logic; redirect overrides the sequential path.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        imm_d   = imm_q;
        len2_d  = len2_q;

        case (state_q)
            ST_IDLE: begin
                if (ien) begin
                    state_d = ST_F1;
                end
            end
            ST_F1: begin
                pc_d    = pc_q + PC_ONE;
                state_d = ST_F1W;
            end
            ST_F1W: begin
                inst_d = iram_data;
                imm_d  = ZERO_DW;
                if (byte1_two) begin
                    len2_d  = 1'b1;
                    state_d = ST_F2;
                end else begin
                    len2_d  = 1'b0;
                    state_d = ST_OUT;
                end
            end
            ST_F2: begin
                pc_d    = pc_q + PC_ONE;
                state_d = ST_F2W;
            end
            ST_F2W: begin
                imm_d   = iram_data;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (xfer) begin
                    if (inst_q == pEND_CODE) begin
                        state_d = ST_HALT;
                    end else if (ien) begin
                        state_d = ST_F1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect abandons any byte being captured: the instruction registers keep their old value.
        if (redirect) begin
            pc_d    = ijmp_addr;
            inst_d  = inst_q;
            imm_d   = imm_q;
            len2_d  = len2_q;
            state_d = ien ? ST_F1 : ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset taking priority over everything.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            imm_q   <= '0;
            len2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            imm_q   <= imm_d;
            len2_q  <= len2_d;
        end
    end

    // Read strobe and address come straight from state; address is parked at zero between reads.
    assign oram_rd    = (state_q == ST_F1) || (state_q == ST_F2);
    assign oram_addr  = oram_rd ? pc_q : ZERO_DW;
    assign oinst_vld  = (state_q == ST_OUT);
    assign oinst_data = inst_q;
    assign oimm_data  = imm_q;
    assign oinst_len2 = len2_q;
    assign opc        = pc_q;
    assign ohalt      = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic       ien = 1'b0;
    logic       oram_rd;
    logic [7:0] oram_addr;
    logic [7:0] iram_data = 8'h00;
    logic       oinst_vld;
    logic       iinst_rdy = 1'b0;
    logic [7:0] oinst_data;
    logic [7:0] oimm_data;
    logic       oinst_len2;
    logic       ijmp = 1'b0;
    logic [7:0] ijmp_addr = 8'h00;
    logic [7:0] opc;
    logic       ohalt;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    cpu_fetch #(.pDATA_WIDTH(8), .pEND_CODE(8'hCF)) dut (
        .iclk       (iclk),
        .irst       (irst),
        .ien        (ien),
        .oram_rd    (oram_rd),
        .oram_addr  (oram_addr),
        .iram_data  (iram_data),
        .oinst_vld  (oinst_vld),
        .iinst_rdy  (iinst_rdy),
        .oinst_data (oinst_data),
        .oimm_data  (oimm_data),
        .oinst_len2 (oinst_len2),
        .ijmp       (ijmp),
        .ijmp_addr  (ijmp_addr),
        .opc        (opc),
        .ohalt      (ohalt)
    );

    always #5 iclk = ~iclk;

    // Synchronous RAM: data one cycle after the strobe, garbage otherwise.
    always @(posedge iclk) begin
        if (oram_rd) iram_data <= mem[oram_addr];
        else         iram_data <= 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        irst = 1'b1; ien = 1'b0; iinst_rdy = 1'b0; ijmp = 1'b0;
        tick(); tick();
        irst = 1'b0;
    endtask

    task automatic wait_rd(input string nm);
        int t = 0;
        while (!oram_rd && t < 20) begin tick(); t++; end
        chk(nm, oram_rd, 1);
    endtask

    task automatic wait_vld(input string nm);
        int t = 0;
        while (!oinst_vld && t < 20) begin tick(); t++; end
        chk(nm, oinst_vld, 1);
    endtask

    function automatic bit is_two(input logic [7:0] b);
        return (b[7:4] == 4'h2) || (b[7:4] == 4'h4) || (b[7:4] == 4'h5);
    endfunction

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] inst;
        logic [7:0] imm;
        logic       len2;
        logic [7:0] pc;
        int         lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{b0:8'h81, b1:8'h00, inst:8'h81, imm:8'h00, len2:1'b0, pc:8'h01, lat:2};
        vecs[1] = '{b0:8'h22, b1:8'h5A, inst:8'h22, imm:8'h5A, len2:1'b1, pc:8'h02, lat:4};
        vecs[2] = '{b0:8'h4A, b1:8'h77, inst:8'h4A, imm:8'h77, len2:1'b1, pc:8'h02, lat:4};
        vecs[3] = '{b0:8'h53, b1:8'h11, inst:8'h53, imm:8'h11, len2:1'b1, pc:8'h02, lat:4};
        vecs[4] = '{b0:8'h30, b1:8'h99, inst:8'h30, imm:8'h00, len2:1'b0, pc:8'h01, lat:2};
        vecs[5] = '{b0:8'h12, b1:8'hEE, inst:8'h12, imm:8'h00, len2:1'b0, pc:8'h01, lat:2};
        vecs[6] = '{b0:8'h6F, b1:8'hAB, inst:8'h6F, imm:8'h00, len2:1'b0, pc:8'h01, lat:2};
        vecs[7] = '{b0:8'h2F, b1:8'h00, inst:8'h2F, imm:8'h00, len2:1'b1, pc:8'h02, lat:4};
        vecs[8] = '{b0:8'hCF, b1:8'h44, inst:8'hCF, imm:8'h00, len2:1'b0, pc:8'h01, lat:2};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset mid-fetch clears every output, including a captured opcode.
        mem[0] = 8'h22; mem[1] = 8'h5A;
        do_reset();
        ien = 1'b1;
        tick(); tick(); tick();
        irst = 1'b1;
        tick();
        irst = 1'b0; ien = 1'b0;
        chk("rst_rd",   oram_rd,    0);
        chk("rst_addr", oram_addr,  0);
        chk("rst_vld",  oinst_vld,  0);
        chk("rst_inst", oinst_data, 0);
        chk("rst_imm",  oimm_data,  0);
        chk("rst_len2", oinst_len2, 0);
        chk("rst_pc",   opc,        0);
        chk("rst_halt", ohalt,      0);

        // Table-driven single-instruction fetches from address 0.
        foreach (vecs[i]) begin
            int t;
            int nrd;
            mem[0] = vecs[i].b0; mem[1] = vecs[i].b1;
            do_reset();
            ien = 1'b1; iinst_rdy = 1'b1;
            tick();
            chk($sformatf("v%0d_rd0", i), oram_rd, 1);
            chk($sformatf("v%0d_addr0", i), oram_addr, 0);
            t = 0; nrd = 0;
            while (!oinst_vld && t < 10) begin
                tick(); t++;
                if (oram_rd) begin
                    nrd++;
                    chk($sformatf("v%0d_addr1", i), oram_addr, 1);
                end
            end
            chk($sformatf("v%0d_lat", i),  t,          vecs[i].lat);
            chk($sformatf("v%0d_nrd", i),  nrd,        vecs[i].len2);
            chk($sformatf("v%0d_inst", i), oinst_data, vecs[i].inst);
            chk($sformatf("v%0d_imm", i),  oimm_data,  vecs[i].imm);
            chk($sformatf("v%0d_len2", i), oinst_len2, vecs[i].len2);
            chk($sformatf("v%0d_pc", i),   opc,        vecs[i].pc);
        end

        // Backpressure: instruction held five cycles, next read the cycle after acceptance.
        mem[0] = 8'h81; mem[1] = 8'h10;
        do_reset();
        ien = 1'b1; iinst_rdy = 1'b0;
        wait_vld("stall_vld_seen");
        for (int k = 0; k < 5; k++) begin
            chk("stall_vld",  oinst_vld,  1);
            chk("stall_inst", oinst_data, 8'h81);
            chk("stall_rd",   oram_rd,    0);
            tick();
        end
        iinst_rdy = 1'b1;
        chk("stall_vld_last", oinst_vld, 1);
        tick();
        iinst_rdy = 1'b0;
        chk("stall_vld_drop", oinst_vld, 0);
        chk("stall_next_rd",  oram_rd,   1);
        chk("stall_next_adr", oram_addr, 1);

        // Redirect during byte-2 capture discards the instruction.
        mem[0] = 8'h22; mem[1] = 8'h5A; mem[8'h40] = 8'h81;
        do_reset();
        ien = 1'b1; iinst_rdy = 1'b1;
        wait_rd("f2w_rd0");
        tick(); tick();
        chk("f2w_rd1",   oram_rd,   1);
        chk("f2w_addr1", oram_addr, 1);
        tick();
        ijmp = 1'b1; ijmp_addr = 8'h40;
        tick();
        ijmp = 1'b0;
        chk("f2w_vld",  oinst_vld, 0);
        chk("f2w_rd",   oram_rd,   1);
        chk("f2w_addr", oram_addr, 8'h40);
        wait_vld("f2w_vld_seen");
        chk("f2w_inst", oinst_data, 8'h81);
        chk("f2w_imm",  oimm_data,  8'h00);
        chk("f2w_len2", oinst_len2, 0);

        // Redirect in the same cycle as an ordinary transfer.
        mem[0] = 8'h81;
        do_reset();
        ien = 1'b1; iinst_rdy = 1'b1;
        wait_vld("xj_vld_seen");
        ijmp = 1'b1; ijmp_addr = 8'h10;
        tick();
        ijmp = 1'b0;
        chk("xj_vld",  oinst_vld, 0);
        chk("xj_rd",   oram_rd,   1);
        chk("xj_addr", oram_addr, 8'h10);

        // PC wrap between byte 1 and byte 2.
        mem[8'hFF] = 8'h40; mem[0] = 8'h9A;
        do_reset();
        ijmp = 1'b1; ijmp_addr = 8'hFF;
        tick();
        ijmp = 1'b0;
        chk("wrap_pc0",  opc,     8'hFF);
        chk("wrap_idle", oram_rd, 0);
        ien = 1'b1; iinst_rdy = 1'b1;
        tick();
        chk("wrap_addr0", oram_addr, 8'hFF);
        tick(); tick();
        chk("wrap_rd1",   oram_rd,   1);
        chk("wrap_addr1", oram_addr, 8'h00);
        wait_vld("wrap_vld_seen");
        chk("wrap_inst", oinst_data, 8'h40);
        chk("wrap_imm",  oimm_data,  8'h9A);
        chk("wrap_len2", oinst_len2, 1);
        chk("wrap_pc",   opc,        8'h01);

        // END accepted together with a redirect: halt wins and is sticky until reset.
        mem[0] = 8'hCF;
        do_reset();
        ien = 1'b1; iinst_rdy = 1'b1;
        wait_vld("end_vld_seen");
        chk("end_inst", oinst_data, 8'hCF);
        ijmp = 1'b1; ijmp_addr = 8'h40;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("halt_flag", ohalt,     1);
            chk("halt_rd",   oram_rd,   0);
            chk("halt_vld",  oinst_vld, 0);
            chk("halt_pc",   opc,       8'h01);
        end
        ijmp = 1'b0;
        irst = 1'b1;
        tick();
        irst = 1'b0;
        chk("unhalt_flag", ohalt, 0);
        chk("unhalt_pc",   opc,   0);

        // Randomized run against a transaction-level model of the fetch stream.
        begin
            logic [7:0] exp_addr;
            logic [7:0] cur [$];
            bit         prev_clr;
            int         nx;
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                if (mem[i] == 8'hCF) mem[i] = 8'hCE;
            end
            do_reset();
            exp_addr = 8'h00; prev_clr = 1'b0; nx = 0;
            cur.delete();
            for (int c = 0; c < 3000; c++) begin
                bit xfer;
                bit jmp;
                chk("rnd_halt", ohalt, 0);
                chk("rnd_pc",   opc,   exp_addr);
                if (prev_clr) chk("rnd_vld_drop", oinst_vld, 0);
                if (oram_rd) begin
                    chk("rnd_addr", oram_addr, exp_addr);
                    cur.push_back(exp_addr);
                    exp_addr = exp_addr + 8'h01;
                end
                if (oinst_vld) begin
                    chk("rnd_vld_has_bytes", cur.size() > 0, 1);
                    if (cur.size() > 0) begin
                        logic [7:0] b1;
                        bit         two;
                        b1  = mem[cur[0]];
                        two = is_two(b1);
                        chk("rnd_nbytes", cur.size(), two ? 2 : 1);
                        chk("rnd_inst",   oinst_data, b1);
                        chk("rnd_len2",   oinst_len2, two);
                        if (two && cur.size() > 1) chk("rnd_imm", oimm_data, mem[cur[1]]);
                        else if (!two)             chk("rnd_imm0", oimm_data, 0);
                    end
                end
                ien       = ($urandom_range(99) < 80);
                iinst_rdy = ($urandom_range(99) < 60);
                ijmp      = ($urandom_range(99) < 5);
                ijmp_addr = 8'($urandom);
                xfer = oinst_vld && iinst_rdy;
                jmp  = ijmp;
                prev_clr = xfer || jmp;
                if (xfer) begin
                    cur.delete();
                    nx++;
                end
                if (jmp) begin
                    exp_addr = ijmp_addr;
                    cur.delete();
                end
                tick();
            end
            ijmp = 1'b0;
            chk("rnd_progress", nx > 150, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 pDATA_WIDTH, 8, width of the data, address, PC and instruction bytes.
REQ-002 pEND_CODE, 8'hCF, instruction byte that halts fetching.
REQ-003 iclk  input  1  clock; all state updates on the rising edge.
REQ-004 irst  input  1  reset, synchronous and active-high.
REQ-005 ien  input  1  fetch enable; no new fetch starts while low.
REQ-006 oram_rd  output  1  RAM read strobe, one cycle per byte.
REQ-007 oram_addr  output  8  RAM read address.
REQ-008 iram_data  input  8  RAM read data, valid exactly one cycle after oram_rd.
REQ-009 oinst_vld  output  1  instruction presented to the control unit.
REQ-010 iinst_rdy  input  1  control unit accepts the presented instruction.
REQ-011 oinst_data  output  8  first instruction byte (opcode plus RA/RB or flag field).
REQ-012 oimm_data  output  8  second byte for 2-byte instructions, else 0.
REQ-013 oinst_len2  output  1  high when the presented instruction is 2 bytes.
REQ-014 ijmp  input  1  redirect pulse from the control unit (JMP, J taken, JMPR).
REQ-015 ijmp_addr  input  8  redirect target address.
REQ-016 opc  output  8  program counter, the address of the next byte to fetch.
REQ-017 ohalt  output  1  END fetched and accepted; fetching stopped.

Function
REQ-018 FSM states: ST_IDLE, ST_F1 (read byte 1), ST_F1W (capture byte 1), ST_F2 (read byte 2), ST_F2W (capture byte 2), ST_OUT (present), ST_HALT.
REQ-019 ST_IDLE -> ST_F1 when ien=1; stay in ST_IDLE otherwise.
REQ-020 ST_F1: oram_rd=1, oram_addr=PC, PC<=PC+1; next state is ST_F1W.
REQ-021 ST_F1W: latch iram_data into oinst_data.
REQ-022 Byte 1 [7:4] = 4'b0010 (DATA), 4'b0100 (JMP) or 4'b0101 (J) -> oinst_len2=1 and next state is ST_F2.
REQ-023 All other byte-1 values -> oinst_len2=1'b0, oimm_data=0, next state is ST_OUT.
REQ-024 ST_F2: oram_rd=1, oram_addr=PC, PC<=PC+1; next state is ST_F2W.
REQ-025 ST_F2W: latch iram_data into oimm_data; next state is ST_OUT.
REQ-026 oram_rd is 0 in every state other than ST_F1 and ST_F2.
REQ-027 ST_OUT: oinst_vld=1, with oinst_data, oimm_data and oinst_len2 held stable until the transfer.
REQ-028 A transfer happens in any cycle with oinst_vld=1 and iinst_rdy=1.
REQ-029 After a transfer, oinst_vld drops the next cycle.
REQ-030 Next state after a transfer:
- ST_HALT if oinst_data==pEND_CODE;
- otherwise ST_F1 if ien=1, else ST_IDLE.
REQ-031 Latency: oram_rd for byte 1 at cycle T; oinst_vld=1 at T+2 for a 1-byte instruction and at T+4 for a 2-byte instruction.
REQ-032 Throughput: the next byte-1 oram_rd is asserted the cycle after a transfer when ien=1.
REQ-033 ien deasserted mid-fetch does not abort the fetch; the current instruction completes and is presented.
REQ-034 PC arithmetic is modulo 256; 8'hFF+1 wraps to 8'h00, including between byte 1 and byte 2.
REQ-035 ijmp=1 in any state except ST_HALT, on the next edge:
- PC<=ijmp_addr;
- oinst_vld<=0;
- any in-flight byte capture is discarded;
- next state is ST_F1 if ien=1, else ST_IDLE.
REQ-036 ijmp in the same cycle as a transfer: the transfer completes, then the jump takes priority over sequential PC.
REQ-037 ijmp in the same cycle as an END transfer: END wins and the block enters ST_HALT.
REQ-038 ST_HALT: ohalt=1, oram_rd=0, oinst_vld=0; ijmp and ien are ignored; only irst exits.
REQ-039 opc always equals the internal PC register.

Reset
REQ-040 irst=1 at an edge forces, at any state including mid-fetch or ST_HALT:
- state=ST_IDLE;
- PC=8'h00;
- oram_rd=0, oram_addr=0;
- oinst_vld=0, oinst_data=0, oimm_data=0, oinst_len2=0;
- ohalt=0.
REQ-041 irst has priority over ijmp, transfers and ien.

Verification
REQ-042 RAM[0]=8'h81, ien=1, iinst_rdy=1 -> oram_rd at T with addr 0; oinst_vld at T+2; oinst_data=8'h81, oinst_len2=0; opc=1.
REQ-043 RAM[0..1]=8'h22,8'h5A -> reads at addr 0 then 1; oinst_vld at T+4; oinst_data=8'h22, oimm_data=8'h5A, oinst_len2=1; opc=2.
REQ-044 iinst_rdy held low 5 cycles during ST_OUT -> oinst_vld and data stable all 5 cycles; no oram_rd until the cycle after iinst_rdy=1.
REQ-045 ijmp=1, ijmp_addr=8'h40 during ST_F2W -> oinst_vld stays 0; the next oram_rd has addr 8'h40; the captured byte is discarded.
REQ-046 PC=8'hFF with RAM[FF]=8'h40 (JMP) -> byte 2 is read from addr 8'h00; opc=8'h01 after the fetch.
REQ-047 RAM[0]=8'hCF accepted -> ohalt=1, no further oram_rd, ijmp ignored; irst=1 -> ohalt=0 and opc=0 on the next cycle.
